quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 42 ++++
 rtl/sync_2ff.sv | 30 +++
 rtl/quad_decoder.sv | 98 +++++++++
 tb/tb_quad_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: state encoding and
// the Gray-to-cycle-position mapping used to classify transitions.
package quad_pkg;

   localparam int unsigned POS_W_DEFAULT = 4;

   typedef enum logic [2:0] {
      INIT,
      Q00,
      Q01,
      Q11,
      Q10
   } quad_state_e;

   function automatic quad_state_e ab_to_state(input logic [1:0] ab);
      quad_state_e s;
      unique case (ab)
         2'b00:   s = Q00;
         2'b01:   s = Q01;
         2'b11:   s = Q11;
         default: s = Q10;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] state_to_ab(input quad_state_e s);
      logic [1:0] ab;
      case (s)
         Q01:     ab = 2'b01;
         Q11:     ab = 2'b11;
         Q10:     ab = 2'b10;
         default: ab = 2'b00;
      endcase
      return ab;
   endfunction

   // Position of an {A,B} code within the forward cycle 00,01,11,10 (Gray to binary).
   function automatic logic [1:0] cycle_pos(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with synchronous
// active-high reset.
module sync_2ff (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, tracks the last {A,B} code and emits
// registered step/dir/pos plus illegal-transition error flags.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned POS_W = POS_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             en,
   input  logic             clr_err,
   output logic             step,
   output logic             dir,
   output logic [POS_W-1:0] pos,
   output logic             err,
   output logic             err_sticky
);

   logic             a_sync, b_sync;
   logic [1:0]       ab;
   logic [1:0]       delta;
   quad_state_e      state_q, state_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             err_q, err_d;
   logic             err_sticky_q, err_sticky_d;

   sync_2ff u_sync_a (
      .clk_i   (CLK),
      .reset_i (reset),
      .d_i     (a_in),
      .q_o     (a_sync)
   );

   sync_2ff u_sync_b (
      .clk_i   (CLK),
      .reset_i (reset),
      .d_i     (b_in),
      .q_o     (b_sync)
   );

   assign ab    = {a_sync, b_sync};
   // 1 = one step forward, 3 = one step back, 2 = both channels flipped.
   assign delta = cycle_pos(ab) - cycle_pos(state_to_ab(state_q));

   always_comb begin
      state_d = ab_to_state(ab);
      step_d  = 1'b0;
      err_d   = 1'b0;
      dir_d   = dir_q;
      pos_d   = pos_q;
      if ((state_q != INIT) && en) begin
         unique case (delta)
            2'd1: begin
               step_d = 1'b1;
               dir_d  = 1'b1;
               pos_d  = pos_q + 1'b1;
            end
            2'd3: begin
               step_d = 1'b1;
               dir_d  = 1'b0;
               pos_d  = pos_q - 1'b1;
            end
            2'd2:    err_d = 1'b1;
            default: ;
         endcase
      end
      err_sticky_d = err_d | (err_sticky_q & ~clr_err);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= INIT;
         step_q       <= 1'b0;
         dir_q        <= 1'b0;
         pos_q        <= '0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         dir_q        <= dir_d;
         pos_q        <= pos_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign step       = step_q;
   assign dir        = dir_q;
   assign pos        = pos_q;
   assign err        = err_q;
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus random
// stimulus, all checked against a cycle-position reference model.
module tb_quad_decoder;

   localparam int unsigned POS_W = 4;
   localparam int PMOD = 1 << POS_W;

   logic             CLK = 1'b0;
   logic             reset = 1'b1;
   logic             a_in = 1'b0;
   logic             b_in = 1'b0;
   logic             en = 1'b1;
   logic             clr_err = 1'b0;
   logic             step, dir, err, err_sticky;
   logic [POS_W-1:0] pos;

   int n_cmp = 0;
   int n_bad = 0;

   quad_decoder #(
      .POS_W (POS_W)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .a_in       (a_in),
      .b_in       (b_in),
      .en         (en),
      .clr_err    (clr_err),
      .step       (step),
      .dir        (dir),
      .pos        (pos),
      .err        (err),
      .err_sticky (err_sticky)
   );

   always #5 CLK = ~CLK;

   // Reference model: the two input samples in flight, the last decoded cycle
   // index (-1 before the first post-reset sample) and an integer position.
   function automatic int cyc_idx(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00;
   int         m_prev = -1;
   int         m_pos = 0;
   logic       m_dir = 1'b0, m_step = 1'b0, m_err = 1'b0, m_sticky = 1'b0;
   int         m_delta;

   assign m_delta = (cyc_idx(m_s2) - m_prev + 4) % 4;

   always @(posedge CLK) begin
      if (reset) begin
         m_s1     <= 2'b00;
         m_s2     <= 2'b00;
         m_prev   <= -1;
         m_pos    <= 0;
         m_dir    <= 1'b0;
         m_step   <= 1'b0;
         m_err    <= 1'b0;
         m_sticky <= 1'b0;
      end else begin
         m_s1   <= {a_in, b_in};
         m_s2   <= m_s1;
         m_prev <= cyc_idx(m_s2);
         m_step <= 1'b0;
         m_err  <= 1'b0;
         if (clr_err) m_sticky <= 1'b0;
         if (m_prev >= 0 && en) begin
            if (m_delta == 1) begin
               m_step <= 1'b1;
               m_dir  <= 1'b1;
               m_pos  <= (m_pos + 1) % PMOD;
            end else if (m_delta == 3) begin
               m_step <= 1'b1;
               m_dir  <= 1'b0;
               m_pos  <= (m_pos + PMOD - 1) % PMOD;
            end else if (m_delta == 2) begin
               m_err    <= 1'b1;
               m_sticky <= 1'b1;
            end
         end
      end
   end

   logic [POS_W+3:0] obs_vec, exp_vec;
   assign obs_vec = {step, dir, pos, err, err_sticky};
   assign exp_vec = {m_step, m_dir, m_pos[POS_W-1:0], m_err, m_sticky};

   task automatic test_reset();
      reset = 1'b1;
      {a_in, b_in} = 2'b00;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if (obs_vec !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", obs_vec);
      end
      n_cmp++;
      if (dut.state_q !== quad_pkg::INIT) begin
         n_bad++;
         $display("FAIL reset_state: got %0d want %0d", int'(dut.state_q), int'(quad_pkg::INIT));
      end
      reset = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         n_cmp++;
         if (obs_vec !== exp_vec || step !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %h want %h", obs_vec, exp_vec);
         end
      end
   endtask

   task automatic test_forward();
      logic [1:0] seq[4];
      int steps = 0;
      seq = '{2'b01, 2'b11, 2'b10, 2'b00};
      for (int i = 0; i < 4; i++) begin
         {a_in, b_in} = seq[i];
         repeat (4) begin
            @(negedge CLK);
            steps += int'(step);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
               n_bad++;
               $display("FAIL forward_model: got %h want %h", obs_vec, exp_vec);
            end
         end
      end
      n_cmp++;
      if (steps != 4 || dir !== 1'b1 || pos !== 4'd4) begin
         n_bad++;
         $display("FAIL forward_end: got steps=%0d dir=%b pos=%0d want 4 1 4", steps, dir, pos);
      end
   endtask

   task automatic test_reverse();
      logic [1:0] seq[5];
      int steps = 0;
      seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
      for (int i = 0; i < 5; i++) begin
         {a_in, b_in} = seq[i];
         repeat (4) begin
            @(negedge CLK);
            steps += int'(step);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
               n_bad++;
               $display("FAIL reverse_model: got %h want %h", obs_vec, exp_vec);
            end
         end
         if (i == 3) begin
            n_cmp++;
            if (steps != 4 || dir !== 1'b0 || pos !== 4'd0) begin
               n_bad++;
               $display("FAIL reverse_end: got steps=%0d dir=%b pos=%0d want 4 0 0",
                        steps, dir, pos);
            end
         end
      end
      n_cmp++;
      if (pos !== 4'd15 || dir !== 1'b0) begin
         n_bad++;
         $display("FAIL reverse_wrap: got pos=%0d dir=%b want 15 0", pos, dir);
      end
   endtask

   task automatic test_error();
      int errs = 0;
      int steps = 0;
      {a_in, b_in} = 2'b00;
      repeat (4) @(negedge CLK);
      n_cmp++;
      if (pos !== 4'd0) begin
         n_bad++;
         $display("FAIL error_setup: got pos=%0d want 0", pos);
      end
      {a_in, b_in} = 2'b11;
      repeat (4) begin
         @(negedge CLK);
         errs  += int'(err);
         steps += int'(step);
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL error_model: got %h want %h", obs_vec, exp_vec);
         end
      end
      n_cmp++;
      if (errs != 1 || steps != 0 || err_sticky !== 1'b1 || pos !== 4'd0) begin
         n_bad++;
         $display("FAIL error_pulse: got errs=%0d steps=%0d sticky=%b pos=%0d want 1 0 1 0",
                  errs, steps, err_sticky, pos);
      end
      clr_err = 1'b1;
      @(negedge CLK);
      clr_err = 1'b0;
      n_cmp++;
      if (err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL error_clear: got sticky=%b want 0", err_sticky);
      end
   endtask

   task automatic test_enable();
      logic [1:0] seq[3];
      int steps = 0;
      int errs = 0;
      seq = '{2'b10, 2'b00, 2'b01};
      en  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) en = 1'b1;
         {a_in, b_in} = seq[i];
         repeat (4) begin
            @(negedge CLK);
            steps += int'(step);
            errs  += int'(err);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
               n_bad++;
               $display("FAIL enable_model: got %h want %h", obs_vec, exp_vec);
            end
         end
      end
      n_cmp++;
      if (steps != 1 || errs != 0 || pos !== 4'd1) begin
         n_bad++;
         $display("FAIL enable_resume: got steps=%0d errs=%0d pos=%0d want 1 0 1",
                  steps, errs, pos);
      end
   endtask

   task automatic test_clr_collision();
      {a_in, b_in} = 2'b10;
      repeat (2) begin
         @(negedge CLK);
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL collide_model: got %h want %h", obs_vec, exp_vec);
         end
      end
      clr_err = 1'b1;
      @(negedge CLK);
      clr_err = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || err_sticky !== 1'b1) begin
         n_bad++;
         $display("FAIL collide_set_wins: got err=%b sticky=%b want 1 1", err, err_sticky);
      end
      @(negedge CLK);
      n_cmp++;
      if (obs_vec !== exp_vec || err_sticky !== 1'b1) begin
         n_bad++;
         $display("FAIL collide_hold: got %h want %h", obs_vec, exp_vec);
      end
   endtask

   task automatic test_reset_midop();
      logic [1:0] fwd[4];
      int steps = 0;
      fwd = '{2'b00, 2'b01, 2'b11, 2'b10};
      for (int n = 0; n < 20 && pos !== 4'd7; n++) begin
         {a_in, b_in} = fwd[(cyc_idx({a_in, b_in}) + 1) % 4];
         repeat (4) begin
            @(negedge CLK);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
               n_bad++;
               $display("FAIL midop_model: got %h want %h", obs_vec, exp_vec);
            end
         end
      end
      n_cmp++;
      if (pos !== 4'd7) begin
         n_bad++;
         $display("FAIL midop_setup: got pos=%0d want 7", pos);
      end
      {a_in, b_in} = fwd[(cyc_idx({a_in, b_in}) + 1) % 4];
      @(negedge CLK);
      reset = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (pos !== 4'd0 || step !== 1'b0 || dut.state_q !== quad_pkg::INIT) begin
         n_bad++;
         $display("FAIL midop_reset: got pos=%0d step=%b state=%0d want 0 0 %0d",
                  pos, step, int'(dut.state_q), int'(quad_pkg::INIT));
      end
      @(negedge CLK);
      reset = 1'b0;
      repeat (6) begin
         @(negedge CLK);
         steps += int'(step);
         n_cmp++;
         if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("FAIL midop_after: got %h want %h", obs_vec, exp_vec);
         end
      end
      n_cmp++;
      if (steps != 0 || pos !== 4'd0) begin
         n_bad++;
         $display("FAIL midop_no_step: got steps=%0d pos=%0d want 0 0", steps, pos);
      end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 120; seg++) begin
         {a_in, b_in} = 2'($urandom_range(0, 3));
         en           = ($urandom_range(0, 9) < 8);
         clr_err      = ($urandom_range(0, 9) == 0);
         reset        = ($urandom_range(0, 39) == 0);
         repeat ($urandom_range(1, 5)) begin
            @(negedge CLK);
            n_cmp++;
            if (obs_vec !== exp_vec || (step & err)) begin
               n_bad++;
               $display("FAIL random_model: got %h want %h", obs_vec, exp_vec);
            end
            reset = 1'b0;
         end
      end
      clr_err = 1'b0;
      en      = 1'b1;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_error();
      test_enable();
      test_clr_collision();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
